// File: rtl/switch_conditioner.sv
// rtl/switch_conditioner.sv - four-channel switch synchronizer, debouncer and hold-to-repeat pulse generator
module switch_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int REPEAT_DELAY    = 50_000_000,
    parameter int REPEAT_PERIOD   = 10_000_000,
    parameter int AUTO_REPEAT     = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic SWITCH1,
    input  logic SWITCH2,
    input  logic SWITCH3,
    input  logic SWITCH4,
    output logic level1,
    output logic level2,
    output logic level3,
    output logic level4,
    output logic pulse1,
    output logic pulse2,
    output logic pulse3,
    output logic pulse4
);

    localparam int DW   = $clog2(DEBOUNCE_CYCLES);
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX);

    localparam logic [DW-1:0] DB_LAST     = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_REPEAT = 2'd2
    } state_t;

    logic [3:0] w_sw;
    logic [3:0] w_level;
    logic [3:0] w_pulse;

    assign w_sw = {SWITCH4, SWITCH3, SWITCH2, SWITCH1};

    for (genvar g = 0; g < 4; g++) begin : g_ch
        logic [1:0]    r_sync;
        logic          r_level;
        logic          r_pulse;
        logic [DW-1:0] r_dcnt;
        logic [RW-1:0] r_rcnt;
        state_t        r_state;
        logic          w_differs;
        logic          w_toggle;

        assign w_differs = (r_sync[1] != r_level);
        assign w_toggle  = w_differs && (r_dcnt == DB_LAST);

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_sync  <= 2'b00;
                r_level <= 1'b0;
                r_dcnt  <= '0;
            end else begin
                r_sync <= {r_sync[0], w_sw[g]};
                if (!w_differs || w_toggle) begin
                    r_dcnt <= '0;
                end else begin
                    r_dcnt <= r_dcnt + DW'(1);
                end
                if (w_toggle) begin
                    r_level <= ~r_level;
                end
            end
        end

        // A debounced level change overrides whatever the repeat machine was doing.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_state <= ST_IDLE;
                r_rcnt  <= '0;
                r_pulse <= 1'b0;
            end else begin
                r_pulse <= 1'b0;
                if (w_toggle) begin
                    r_rcnt <= '0;
                    if (!r_level) begin
                        r_state <= ST_HOLD;
                        r_pulse <= 1'b1;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end else begin
                    case (r_state)
                        ST_IDLE: begin
                            r_rcnt <= '0;
                        end
                        ST_HOLD: begin
                            if (AUTO_REPEAT != 0) begin
                                if (r_rcnt == DELAY_LAST) begin
                                    r_rcnt  <= '0;
                                    r_pulse <= 1'b1;
                                    r_state <= ST_REPEAT;
                                end else begin
                                    r_rcnt <= r_rcnt + RW'(1);
                                end
                            end
                        end
                        ST_REPEAT: begin
                            if (r_rcnt == PERIOD_LAST) begin
                                r_rcnt  <= '0;
                                r_pulse <= 1'b1;
                            end else begin
                                r_rcnt <= r_rcnt + RW'(1);
                            end
                        end
                        default: begin
                            r_state <= ST_IDLE;
                            r_rcnt  <= '0;
                        end
                    endcase
                end
            end
        end

        assign w_level[g] = r_level;
        assign w_pulse[g] = r_pulse;
    end

    assign level1 = w_level[0];
    assign level2 = w_level[1];
    assign level3 = w_level[2];
    assign level4 = w_level[3];
    assign pulse1 = w_pulse[0];
    assign pulse2 = w_pulse[1];
    assign pulse3 = w_pulse[2];
    assign pulse4 = w_pulse[3];

endmodule

// File: tb/tb_switch_conditioner.sv
// tb/tb_switch_conditioner.sv - scoreboard bench for switch_conditioner against a window/arithmetic reference model
module tb_switch_conditioner;

    localparam int DC = 4;
    localparam int RD = 20;
    localparam int RP = 8;
    localparam int NT = 16384;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] sw;
    logic [3:0] lvl, pul, lvl_n, pul_n;

    always #5 clk = ~clk;

    switch_conditioner #(
        .DEBOUNCE_CYCLES(DC), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .AUTO_REPEAT(1)
    ) u_dut (
        .clk(clk), .rst(rst),
        .SWITCH1(sw[0]), .SWITCH2(sw[1]), .SWITCH3(sw[2]), .SWITCH4(sw[3]),
        .level1(lvl[0]), .level2(lvl[1]), .level3(lvl[2]), .level4(lvl[3]),
        .pulse1(pul[0]), .pulse2(pul[1]), .pulse3(pul[2]), .pulse4(pul[3])
    );

    switch_conditioner #(
        .DEBOUNCE_CYCLES(DC), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .AUTO_REPEAT(0)
    ) u_dut_nr (
        .clk(clk), .rst(rst),
        .SWITCH1(sw[0]), .SWITCH2(sw[1]), .SWITCH3(sw[2]), .SWITCH4(sw[3]),
        .level1(lvl_n[0]), .level2(lvl_n[1]), .level3(lvl_n[2]), .level4(lvl_n[3]),
        .pulse1(pul_n[0]), .pulse2(pul_n[1]), .pulse3(pul_n[2]), .pulse4(pul_n[3])
    );

    int          tests = 0;
    int          fails = 0;
    int          t = 0;
    logic [3:0]  hist [NT];
    logic [3:0]  m_level = 4'b0;
    int          press [4];
    logic [15:0] exp_q [$];
    logic [15:0] mon_exp, mon_act;
    int          nr4_count = 0;
    logic        count_en = 1'b0;

    // Model: level flips once the last DC synchronized samples all disagree with it;
    // pulses fall at press, press+RD, then every RP while still held.
    task automatic step(input logic r, input logic [3:0] s);
        logic [3:0] pa, pn;
        logic       all_diff, v;
        int         d;
        rst = r;
        sw  = s;
        hist[t] = r ? s : 4'b0;
        pa = 4'b0;
        pn = 4'b0;
        if (!r) begin
            if (t > 0) hist[t-1] = 4'b0;
            m_level = 4'b0;
        end else begin
            for (int ch = 0; ch < 4; ch++) begin
                all_diff = 1'b1;
                for (int k = t - 1 - DC; k <= t - 2; k++) begin
                    v = (k >= 0) ? hist[k][ch] : 1'b0;
                    if (v == m_level[ch]) all_diff = 1'b0;
                end
                if (all_diff) begin
                    m_level[ch] = ~m_level[ch];
                    if (m_level[ch]) press[ch] = t;
                end
                if (m_level[ch]) begin
                    d = t - press[ch];
                    pn[ch] = (d == 0);
                    pa[ch] = (d == 0) || (d == RD) || (d > RD && ((d - RD) % RP) == 0);
                end
            end
        end
        exp_q.push_back({m_level, pa, m_level, pn});
        t++;
        @(negedge clk);
    endtask

    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_exp = exp_q.pop_front();
            mon_act = {lvl, pul, lvl_n, pul_n};
            tests++;
            if (mon_act !== mon_exp) begin
                fails++;
                $display("FAIL outputs edge %0d: got lvl/pul/lvl_n/pul_n=%b required %b", t, mon_act, mon_exp);
            end
            if (count_en && pul_n[3]) nr4_count++;
        end
    end

    initial begin
        logic       pat [8];
        logic [3:0] rs;
        pat = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        rst = 1'b0;
        sw  = 4'b0;
        for (int i = 0; i < 4; i++) press[i] = 0;
        @(negedge clk);

        repeat (10) step(1'b0, 4'($urandom_range(0, 15)));
        repeat (10) step(1'b1, 4'b0000);

        repeat (15) step(1'b1, 4'b0001);
        repeat (12) step(1'b1, 4'b0000);

        for (int i = 0; i < 8; i++) step(1'b1, pat[i] ? 4'b0010 : 4'b0000);
        repeat (8)  step(1'b1, 4'b0010);
        repeat (12) step(1'b1, 4'b0000);

        repeat (62) step(1'b1, 4'b0100);
        repeat (12) step(1'b1, 4'b0000);

        count_en = 1'b1;
        repeat (110) step(1'b1, 4'b1000);
        repeat (12)  step(1'b1, 4'b0000);
        count_en = 1'b0;
        tests++;
        if (nr4_count != 1) begin
            fails++;
            $display("FAIL no_repeat_pulse_count: got %0d required 1", nr4_count);
        end

        repeat (12) step(1'b1, 4'b1001);
        repeat (12) step(1'b1, 4'b0000);

        repeat (5)  step(1'b0, 4'b0010);
        repeat (15) step(1'b1, 4'b0010);
        repeat (12) step(1'b1, 4'b0000);

        // Asynchronous clear checked between clock edges while channel 3 is repeating.
        repeat (40) step(1'b1, 4'b0100);
        rst = 1'b0;
        #1;
        tests++;
        if ({lvl, pul, lvl_n, pul_n} !== 16'h0) begin
            fails++;
            $display("FAIL async_reset: got %b required %b", {lvl, pul, lvl_n, pul_n}, 16'h0);
        end
        repeat (3)  step(1'b0, 4'b0100);
        repeat (12) step(1'b1, 4'b0000);

        rs = 4'b0;
        repeat (3000) begin
            for (int ch = 0; ch < 4; ch++)
                if ($urandom_range(0, 11) == 0) rs[ch] = ~rs[ch];
            step(($urandom_range(0, 299) != 0), rs);
        end
        repeat (15) step(1'b1, 4'b0000);

        repeat (2) @(posedge clk);
        #2;
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: got %0d pending required 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
